// File: rtl/prim_xor_pkg.sv
// prim_xor_pkg: shared types and constants for the XOR accumulator primitive.
package prim_xor_pkg;
  typedef enum logic {
    XorCombine = 1'b0,
    XorAccum   = 1'b1
  } xor_mode_e;
  typedef enum logic {
    OutEmpty = 1'b0,
    OutFull  = 1'b1
  } out_state_e;
  localparam int XorCountW = 16;
  localparam logic [XorCountW-1:0] XorCountMax = 16'hFFFF;
endpackage

// File: rtl/prim_generic_xor2.sv
// prim_generic_xor2: two-input bitwise XOR primitive.
module prim_generic_xor2 #(
  parameter int Width = 1
) (
  input  logic [Width-1:0] in0_i,
  input  logic [Width-1:0] in1_i,
  output logic [Width-1:0] out_o
);
  assign out_o = in0_i ^ in1_i;
endmodule

// File: rtl/prim_xor_tree.sv
// prim_xor_tree: combinational balanced XOR reduction of NumIn lanes.
module prim_xor_tree #(
  parameter int Width = 32,
  parameter int NumIn = 2
) (
  input  logic [NumIn*Width-1:0] data_i,
  output logic [Width-1:0]       data_o
);
  if (NumIn == 1) begin : g_leaf
    assign data_o = data_i;
  end else begin : g_split
    // Split into near-equal halves so the depth stays ceil(log2(NumIn)).
    localparam int Lo = NumIn / 2;
    localparam int Hi = NumIn - Lo;
    logic [Width-1:0] lo, hi;
    prim_xor_tree #(.Width(Width), .NumIn(Lo)) u_lo (
      .data_i(data_i[Lo*Width-1:0]),
      .data_o(lo)
    );
    prim_xor_tree #(.Width(Width), .NumIn(Hi)) u_hi (
      .data_i(data_i[NumIn*Width-1:Lo*Width]),
      .data_o(hi)
    );
    prim_generic_xor2 #(.Width(Width)) u_xor (
      .in0_i(lo),
      .in1_i(hi),
      .out_o(data_o)
    );
  end
endmodule

// File: rtl/prim_xor_accum.sv
// prim_xor_accum: registered NumIn-lane XOR reducer with accumulator and valid/ready output.
// Define PRIM_XOR_ACCUM_PARITY_EN to add the registered out_parity_o port.
module prim_xor_accum
  import prim_xor_pkg::*;
#(
  parameter int Width = 32,
  parameter int NumIn = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 mode_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [NumIn*Width-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [Width-1:0]     out_data_o,
  output logic [Width-1:0]     acc_o,
`ifdef PRIM_XOR_ACCUM_PARITY_EN
  output logic                 out_parity_o,
`endif
  output logic [XorCountW-1:0] count_o
);
  if (NumIn < 2 || Width < 1) begin : g_bad_param
    $error("prim_xor_accum: requires NumIn >= 2 and Width >= 1");
  end
  out_state_e state_d, state_q;
  logic [Width-1:0] reduced, acc_base, acc_next;
  logic [Width-1:0] out_data_d, out_data_q, acc_d, acc_q;
  logic [XorCountW-1:0] count_base, count_d, count_q;
  logic accept, is_accum;
  prim_xor_tree #(.Width(Width), .NumIn(NumIn)) u_tree (
    .data_i(in_data_i),
    .data_o(reduced)
  );
  assign out_valid_o = state_q == OutFull;
  assign in_ready_o  = !out_valid_o || out_ready_i;
  assign accept      = in_valid_i && in_ready_o;
  assign is_accum    = xor_mode_e'(mode_i) == XorAccum;
  always_comb begin
    state_d    = accept ? OutFull : (out_ready_i ? OutEmpty : state_q);
    acc_base   = clear_i ? '0 : acc_q;
    count_base = clear_i ? '0 : count_q;
    acc_next   = acc_base ^ reduced;
    out_data_d = accept ? (is_accum ? acc_next : reduced) : out_data_q;
    acc_d      = (accept && is_accum) ? acc_next : acc_base;
    count_d    = (accept && is_accum && count_base != XorCountMax) ? count_base + 1'b1 : count_base;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= OutEmpty;
      out_data_q <= '0;
      acc_q      <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
    end
  end
  assign out_data_o = out_data_q;
  assign acc_o      = acc_q;
  assign count_o    = count_q;
`ifdef PRIM_XOR_ACCUM_PARITY_EN
  logic out_parity_d, out_parity_q;
  assign out_parity_d = accept ? ^out_data_d : out_parity_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) out_parity_q <= 1'b0;
    else         out_parity_q <= out_parity_d;
  end
  assign out_parity_o = out_parity_q;
`endif
endmodule
